uart_send_fifo: RTL
===================

Name: uart_send_fifo

Overview:
Buffered UART transmitter: the opposite direction of the board's uart_recv path. It accepts bytes through a single-cycle strobe into an internal FIFO and serialises them on the TX pin as 8N1 frames (LSB first, idle high). It sits between byte producers (send_ctrl, string_match) and the uart_tx pin, so producers can burst several bytes back-to-back without tracking line timing.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD, 9600, line rate in baud.
BIT_CYCLES, CLK_FREQ/BAUD (integer division; 10416 at defaults), clock cycles per bit; ≥2.
DEPTH, 16, FIFO depth in bytes; power of two, ≥2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
valid  input  1  write strobe; data is sampled on a rising edge where valid=1.
data  input  8  byte to queue.
full  output  1  FIFO holds DEPTH bytes; a write this cycle is rejected.
overflow  output  1  one-cycle pulse when valid=1 while full=1 (byte dropped).
busy  output  1  1 while a frame is in progress or the FIFO is non-empty.
uart_tx  output  1  serial line.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty (count=0, pointers 0), FSM=IDLE, bit counter 0, uart_tx=1, full=0, overflow=0, busy=0. Asserting reset mid-frame aborts the frame immediately; the line returns high with no stop bit.
- FIFO: count register 0..DEPTH. full = (count==DEPTH), decoded from the registered count.
  - Write accepted iff valid && !full.
  - Accepted write and pop in the same cycle: count unchanged, both take effect.
  - While full, writes are rejected even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: uart_tx=1. If count>0 (registered), pop the head byte into the shift register, clear the bit counter, go to START.
  - START: uart_tx=0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for BIT_CYCLES cycles per bit. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: uart_tx=1 for BIT_CYCLES cycles. Then go to IDLE, or go directly to START with the next popped byte if count>0 (no idle gap between queued frames).
- uart_tx is registered (glitch-free).
- Latency: a byte accepted at edge N into an empty FIFO with FSM idle is popped at edge N+1. uart_tx falls after edge N+2, i.e. the start bit begins 2 cycles after acceptance.
- Frame length: exactly 10*BIT_CYCLES cycles from the uart_tx falling edge to the end of the stop bit.
- busy = (FSM != IDLE) || (count != 0). busy deasserts the cycle after the last stop bit completes with an empty FIFO.
- overflow is registered and pulses for 1 cycle per rejected write. A held valid while full pulses every cycle.
- The data path never blocks on valid timing; valid may be asserted on consecutive cycles.

Test Plan:
1. CLK_FREQ=100, BAUD=10 (BIT_CYCLES=10). Reset, then write 8'h55 -> uart_tx low 2 cycles after the write. The line shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each level held exactly 10 cycles. busy falls after 100 line cycles.
2. Back-to-back writes 8'h41, 8'h42, 8'h43 on 3 consecutive cycles -> three contiguous frames, 300 cycles total with no idle gap. The decoded bytes are 41, 42, 43 in order.
3. DEPTH=4, FSM held busy, 6 writes on consecutive cycles -> the first byte is popped immediately. full asserts after the 5th accepted byte (1 shifting + 4 queued). The 6th write raises overflow for 1 cycle. Exactly 5 frames are emitted.
4. Fill to full, then write on the cycle a STOP completes and pops -> the write is rejected (overflow=1). count goes to DEPTH-1 and full deasserts on the next edge.
5. Drive rst=0 asynchronously during DATA bit 3 of 8'hA5 -> uart_tx=1, busy=0, full=0 without waiting for a clock edge. After release, a write of 8'h00 produces a clean frame.
6. Default parameters, send 8'h0D -> each bit lasts 10416 cycles at 100 MHz, and a uart_recv loopback reports valid with data=8'h0D.

Source files
------------

// File: rtl/uart_send_fifo.sv
// Buffered 8N1 UART transmitter.
// Bytes arrive on a single-cycle strobe, queue in a small FIFO and are
// serialised LSB first on uart_tx. Queued frames are sent back to back,
// with no idle gap between a stop bit and the next start bit.
module uart_send_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int BIT_CYCLES = CLK_FREQ / BAUD,
  parameter int DEPTH      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       uart_tx
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0] CYC_ONE  = 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

  logic [1:0]    state;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    shift;
  logic [CW-1:0] cyc;
  logic [2:0]    bit_idx;
  logic          bit_end;
  logic          wr_en;
  logic          pop;
  logic          tx_next;

  // full is decoded from the registered count, so a pop in the same cycle
  // cannot make room for a write that arrives while full.
  assign full    = (count == FULL_CNT);
  assign wr_en   = valid && !full;
  assign bit_end = (cyc == LAST_CYC);
  // Pop from IDLE, or at the very end of a stop bit to chain the next frame.
  assign pop     = (count != '0) &&
                   ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign busy    = (state != S_IDLE) || (count != '0);

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: bit timing counter and data bit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cyc     <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_START;
            cyc   <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            cyc     <= '0;
            bit_idx <= '0;
          end else begin
            cyc <= cyc + CYC_ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cyc <= '0;
            if (bit_idx == 3'd7) state   <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cyc <= cyc + CYC_ONE;
          end
        end
        default: begin
          if (bit_end) begin
            cyc   <= '0;
            state <= pop ? S_START : S_IDLE;
          end else begin
            cyc <= cyc + CYC_ONE;
          end
        end
      endcase
    end
  end

  // Shift register: load on pop, move to the next data bit at each bit end.
  always_ff @(posedge clk) begin
    if (pop)                             shift <= mem[rd_ptr];
    else if ((state == S_DATA) && bit_end) shift <= {1'b0, shift[7:1]};
  end

  // Line level implied by the current state.
  always_comb begin
    tx_next = 1'b1;
    case (state)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shift[0];
      default: tx_next = 1'b1;
    endcase
  end

  // Registered TX pin; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) uart_tx <= 1'b1;
    else      uart_tx <= tx_next;
  end

  // One pulse per rejected write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else      overflow <= valid && full;
  end

endmodule
